sound_dma_channel: RTL

- Single 8-bit, 8237-style DMA channel engine. It is the responder end of the Sound Blaster DMA handshake: it answers the DSP's req with ack, data and terminal.
- Moves bytes between 24-bit system memory (Avalon-style master) and the DSP, in either direction.
- Has its own small register file, programmed by the CPU through an io slave.
- Sits in the SoC beside the sound block and replaces a generic multi-channel controller for the SB path.

---
 rtl/sound_dma_pkg.sv | 32 +++
 rtl/sound_dma_regs.sv | 132 +++++++++++++
 rtl/sound_dma_channel.sv | 116 +++++++++++
 3 files changed

// File: rtl/sound_dma_pkg.sv
// Shared constants for the single-channel Sound Blaster DMA engine: FSM states,
// register offsets and mode field encodings.
package sound_dma_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MRD      = 3'd1;
  localparam logic [2:0] ST_MRD_WAIT = 3'd2;
  localparam logic [2:0] ST_ACK      = 3'd3;
  localparam logic [2:0] ST_MWR      = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam logic [2:0] REG_ADDR   = 3'd0;
  localparam logic [2:0] REG_COUNT  = 3'd1;
  localparam logic [2:0] REG_PAGE   = 3'd2;
  localparam logic [2:0] REG_MODE   = 3'd3;
  localparam logic [2:0] REG_MASK   = 3'd4;
  localparam logic [2:0] REG_CLR_FF = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;

  localparam logic [1:0] XFER_VERIFY = 2'b00;
  localparam logic [1:0] XFER_WRITE  = 2'b01;
  localparam logic [1:0] XFER_READ   = 2'b10;

  localparam int MODE_AUTOINIT_BIT = 4;
  localparam int MODE_DEC_BIT      = 5;

  // Encoding 11 has no transfer meaning and behaves as verify.
  function automatic logic [1:0] decode_xfer(input logic [1:0] field);
    return (field == 2'b11) ? XFER_VERIFY : field;
  endfunction

endpackage

// File: rtl/sound_dma_regs.sv
// CPU-visible register file for the DMA channel: base/current address and count,
// page, mode, mask, TC status and the shared low/high byte flip-flop.
module sound_dma_regs
  import sound_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  io_address,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [7:0]  io_writedata,
  output logic [7:0]  io_readdata,
  input  logic        dma_req,
  input  logic        xfer_start,
  input  logic        xfer_done,
  output logic [7:0]  page,
  output logic [15:0] cur_addr,
  output logic [15:0] cur_count,
  output logic [1:0]  xfer_mode,
  output logic        mask
);

  logic [15:0] base_addr;
  logic [15:0] base_count;
  logic [3:0]  mode_q;
  logic        ff;
  logic        tc;
  logic        addr_wr;
  logic        count_wr;
  logic        sel_addr;
  logic        sel_count;
  logic        terminal;
  logic        auto_init;
  logic        dec;
  logic [15:0] next_addr;

  assign sel_addr  = (io_address == REG_ADDR);
  assign sel_count = (io_address == REG_COUNT);
  assign auto_init = mode_q[MODE_AUTOINIT_BIT-2];
  assign dec       = mode_q[MODE_DEC_BIT-2];
  assign xfer_mode = decode_xfer(mode_q[1:0]);
  assign terminal  = xfer_done && (cur_count == 16'h0000);
  assign next_addr = dec ? (cur_addr - 16'd1) : (cur_addr + 16'd1);

  always_comb begin
    io_readdata = 8'hFF;
    case (io_address)
      REG_ADDR:   io_readdata = ff ? cur_addr[15:8] : cur_addr[7:0];
      REG_COUNT:  io_readdata = ff ? cur_count[15:8] : cur_count[7:0];
      REG_STATUS: io_readdata = {6'b0, dma_req, tc};
      default:    io_readdata = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr  <= '0;
      base_count <= '0;
      cur_addr   <= '0;
      cur_count  <= '0;
      page       <= '0;
      mode_q     <= '0;
      mask       <= 1'b1;
      ff         <= 1'b0;
      tc         <= 1'b0;
      addr_wr    <= 1'b0;
      count_wr   <= 1'b0;
    end else begin
      if (io_write && io_address == REG_CLR_FF)
        ff <= 1'b0;
      else if ((io_read || io_write) && (sel_addr || sel_count))
        ff <= ~ff;

      if (io_read && io_address == REG_STATUS)
        tc <= 1'b0;

      if (xfer_start) begin
        addr_wr  <= 1'b0;
        count_wr <= 1'b0;
      end

      // Byte completion; anything the CPU wrote since the byte started is kept.
      if (xfer_done) begin
        if (terminal) begin
          tc <= 1'b1;
          if (auto_init) begin
            if (!addr_wr)  cur_addr  <= base_addr;
            if (!count_wr) cur_count <= base_count;
          end else begin
            mask <= 1'b1;
            if (!addr_wr)  cur_addr  <= next_addr;
            if (!count_wr) cur_count <= cur_count - 16'd1;
          end
        end else begin
          if (!addr_wr)  cur_addr  <= next_addr;
          if (!count_wr) cur_count <= cur_count - 16'd1;
        end
      end

      // CPU writes come last so they win over the completion update.
      if (io_write) begin
        case (io_address)
          REG_ADDR: begin
            addr_wr <= 1'b1;
            if (ff) begin
              base_addr[15:8] <= io_writedata;
              cur_addr[15:8]  <= io_writedata;
            end else begin
              base_addr[7:0] <= io_writedata;
              cur_addr[7:0]  <= io_writedata;
            end
          end
          REG_COUNT: begin
            count_wr <= 1'b1;
            if (ff) begin
              base_count[15:8] <= io_writedata;
              cur_count[15:8]  <= io_writedata;
            end else begin
              base_count[7:0] <= io_writedata;
              cur_count[7:0]  <= io_writedata;
            end
          end
          REG_PAGE: page   <= io_writedata;
          REG_MODE: mode_q <= io_writedata[5:2];
          REG_MASK: mask   <= io_writedata[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/sound_dma_channel.sv
// 8237-style single 8-bit DMA channel answering the DSP req with ack/terminal,
// moving bytes between the DSP and 24-bit memory through an Avalon-style master.
module sound_dma_channel
  import sound_dma_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        io_address,
  input  logic              io_read,
  output logic [7:0]        io_readdata,
  input  logic              io_write,
  input  logic [7:0]        io_writedata,
  input  logic              dma_req,
  output logic              dma_ack,
  output logic              dma_terminal,
  output logic [7:0]        dma_readdata,
  input  logic [7:0]        dma_writedata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [7:0]        mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [7:0]        mem_readdata,
  input  logic              mem_readdatavalid
);

  logic [2:0]  state;
  logic [1:0]  xfer;
  logic [7:0]  data_q;
  logic [7:0]  page;
  logic [15:0] cur_addr;
  logic [15:0] cur_count;
  logic [1:0]  xfer_mode;
  logic        mask;
  logic        xfer_start;

  assign xfer_start = (state == ST_IDLE) && dma_req && !mask;

  sound_dma_regs u_regs (
    .clk          (clk),
    .rst_n        (rst_n),
    .io_address   (io_address),
    .io_read      (io_read),
    .io_write     (io_write),
    .io_writedata (io_writedata),
    .io_readdata  (io_readdata),
    .dma_req      (dma_req),
    .xfer_start   (xfer_start),
    .xfer_done    (dma_ack),
    .page         (page),
    .cur_addr     (cur_addr),
    .cur_count    (cur_count),
    .xfer_mode    (xfer_mode),
    .mask         (mask)
  );

  // Decoded from the state flop so reset clears them without waiting for a clock.
  assign mem_read      = (state == ST_MRD);
  assign mem_write     = (state == ST_MWR);
  assign mem_writedata = (state == ST_MWR) ? data_q : 8'h00;
  assign dma_ack       = (state == ST_ACK);
  assign dma_terminal  = dma_ack && (cur_count == 16'h0000);
  assign dma_readdata  = (dma_ack && xfer == XFER_READ) ? data_q : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      xfer        <= XFER_VERIFY;
      data_q      <= '0;
      mem_address <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer_start) begin
            mem_address <= ADDR_W'({page, cur_addr});
            xfer        <= xfer_mode;
            data_q      <= '0;
            state       <= (xfer_mode == XFER_READ) ? ST_MRD : ST_ACK;
          end
        end
        ST_MRD: begin
          if (!mem_waitrequest) begin
            if (mem_readdatavalid) begin
              data_q <= mem_readdata;
              state  <= ST_ACK;
            end else begin
              state <= ST_MRD_WAIT;
            end
          end
        end
        ST_MRD_WAIT: begin
          if (mem_readdatavalid) begin
            data_q <= mem_readdata;
            state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (xfer == XFER_WRITE) begin
            data_q <= dma_writedata;
            state  <= ST_MWR;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_MWR: begin
          if (!mem_waitrequest) state <= ST_GAP;
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
